// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity modes and counter width for the UART transmitter
package uart_pkg;
  localparam int CNT_W = 13;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two circular transmit buffer with occupancy count
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            data,
  output logic [W-1:0]            q,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != (AW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign q = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= data;
  // Pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with configurable width, parity and stop bits
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = 1736,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY_MODE = PAR_NONE,
  parameter int      STOP_BITS = 1,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic [DATA_BITS-1:0]         data_i,
  output logic                         ready_o,
  output logic                         bit_o,
  output logic                         active_o,
  output logic                         done_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
  uart_state_t state;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, head;
  logic par, bit_end, last_data, last_stop, pop;
  assign ready_o = fifo_count_o != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
  assign bit_end = clk_cnt == CNT_W'(CLKS_PER_BIT - 1);
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign done_o = state == STOP && bit_end && last_stop;
  // A queued word starts from idle or straight out of the final stop cycle
  assign pop = fifo_count_o != '0 && (state == IDLE || done_o);
  assign active_o = state != IDLE;
  always_comb bit_o = state == START ? 1'b0 : state == DATA ? shreg[0] : state == PARITY ? par : 1'b1;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(valid_i && ready_o),
    .pop(pop),
    .data(data_i),
    .q(head),
    .count(fifo_count_o)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
    end else if (pop) begin
      state <= START;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg <= head;
      par <= ^head ^ (PARITY_MODE == PAR_ODD);
    end else if (state != IDLE) begin
      if (!bit_end) clk_cnt <= clk_cnt + 1'b1;
      else begin
        clk_cnt <= '0;
        bit_cnt <= (state == DATA && !last_data) || (state == STOP && !last_stop) ? bit_cnt + 1'b1 : '0;
        if (state == DATA) shreg <= shreg >> 1;
        state <= state == START ? DATA
               : state == DATA ? (last_data ? (PARITY_MODE == PAR_NONE ? STOP : PARITY) : DATA)
               : state == PARITY ? STOP
               : last_stop ? IDLE : STOP;
      end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked cycle by cycle against a frame-level model
module tb_uart_tx_param;
  import uart_pkg::*;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid [4];
  logic [8:0] data [4];
  logic bit_w [4], act_w [4], done_w [4], rdy_w [4];
  logic [2:0] cnt_w [4];
  int dbits [4] = '{8, 8, 8, 5};
  int pmode [4] = '{0, 1, 2, 0};
  int nstop [4] = '{1, 1, 1, 2};
  logic line_q [4][$];
  logic [8:0] fifo_q [4][$];
  int act_cnt [4], done_cnt [4], act0 [4], done0 [4];
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[0]), .data_i(data[0][7:0]), .ready_o(rdy_w[0]),
    .bit_o(bit_w[0]), .active_o(act_w[0]), .done_o(done_w[0]), .fifo_count_o(cnt_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[1]), .data_i(data[1][7:0]), .ready_o(rdy_w[1]),
    .bit_o(bit_w[1]), .active_o(act_w[1]), .done_o(done_w[1]), .fifo_count_o(cnt_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d2 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[2]), .data_i(data[2][7:0]), .ready_o(rdy_w[2]),
    .bit_o(bit_w[2]), .active_o(act_w[2]), .done_o(done_w[2]), .fifo_count_o(cnt_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) d3 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[3]), .data_i(data[3][4:0]), .ready_o(rdy_w[3]),
    .bit_o(bit_w[3]), .active_o(act_w[3]), .done_o(done_w[3]), .fifo_count_o(cnt_w[3]));

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void add_bit(int d, logic b);
    repeat (CPB) line_q[d].push_back(b);
  endfunction

  // Expected line: one entry per clock cycle of the whole frame
  function automatic void load_frame(int d, logic [8:0] w);
    add_bit(d, 1'b0);
    for (int i = 0; i < dbits[d]; i++) add_bit(d, w[i]);
    if (pmode[d] != 0) add_bit(d, ^w ^ (pmode[d] == 2));
    for (int i = 0; i < nstop[d]; i++) add_bit(d, 1'b1);
  endfunction

  initial forever begin : model
    int n;
    logic acc;
    logic [8:0] w;
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 4; d++)
      if (!rst_n) begin
        line_q[d].delete();
        fifo_q[d].delete();
      end else begin
        n = fifo_q[d].size();
        acc = valid[d] && n < DEPTH;
        w = data[d] & 9'((1 << dbits[d]) - 1);
        if (line_q[d].size() != 0) void'(line_q[d].pop_front());
        if (line_q[d].size() == 0 && n > 0) load_frame(d, fifo_q[d].pop_front());
        if (acc) fifo_q[d].push_back(w);
      end
  end

  always @(negedge clk)
    for (int d = 0; d < 4; d++) begin
      check($sformatf("d%0d_bit", d), bit_w[d], line_q[d].size() == 0 ? 1 : int'(line_q[d][0]));
      check($sformatf("d%0d_active", d), act_w[d], line_q[d].size() != 0);
      check($sformatf("d%0d_done", d), done_w[d], line_q[d].size() == 1);
      check($sformatf("d%0d_count", d), cnt_w[d], fifo_q[d].size());
      check($sformatf("d%0d_ready", d), rdy_w[d], fifo_q[d].size() < DEPTH);
      act_cnt[d] += int'(act_w[d]);
      done_cnt[d] += int'(done_w[d]);
    end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int d, logic [8:0] w);
    valid[d] = 1'b1;
    data[d] = w;
    @(negedge clk);
    valid[d] = 1'b0;
  endtask

  task automatic mark();
    #2;
    for (int d = 0; d < 4; d++) begin
      act0[d] = act_cnt[d];
      done0[d] = done_cnt[d];
    end
    @(negedge clk);
  endtask

  task automatic delta(int d, int act, int done);
    #2;
    check($sformatf("d%0d_active_cycles", d), act_cnt[d] - act0[d], act);
    check($sformatf("d%0d_done_pulses", d), done_cnt[d] - done0[d], done);
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      valid[d] = 1'b0;
      data[d] = '0;
      act_cnt[d] = 0;
      done_cnt[d] = 0;
    end
    #1;
    check("rst_bit", bit_w[0], 1);
    check("rst_active", act_w[0], 0);
    check("rst_done", done_w[0], 0);
    check("rst_ready", rdy_w[0], 1);
    check("rst_count", cnt_w[0], 0);
    cycles(3);
    #1 rst_n = 1'b1;
    @(negedge clk);
    mark();
    push(0, 9'h0A5);
    cycles(50);
    delta(0, 40, 1);
    mark();
    valid[1] = 1'b1;
    valid[2] = 1'b1;
    data[1] = 9'h007;
    data[2] = 9'h007;
    @(negedge clk);
    valid[1] = 1'b0;
    valid[2] = 1'b0;
    cycles(39);
    check("even_parity_bit", bit_w[1], 1);
    check("odd_parity_bit", bit_w[2], 0);
    cycles(10);
    delta(1, 44, 1);
    delta(2, 44, 1);
    mark();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("full_ready", rdy_w[0], 0);
      valid[0] = 1'b1;
      data[0] = 9'($urandom);
      @(negedge clk);
    end
    valid[0] = 1'b0;
    cycles(220);
    delta(0, 200, 5);
    for (int i = 0; i < 3; i++) push(0, 9'($urandom));
    cycles(38);
    check("pp_count_before", cnt_w[0], 2);
    check("pp_done", done_w[0], 1);
    push(0, 9'($urandom));
    check("pp_count_after", cnt_w[0], 2);
    cycles(130);
    for (int i = 0; i < 3; i++) push(0, 9'($urandom));
    cycles(12);
    check("rst_pre_active", act_w[0], 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_bit", bit_w[0], 1);
    check("rst_mid_active", act_w[0], 0);
    check("rst_mid_count", cnt_w[0], 0);
    check("rst_mid_ready", rdy_w[0], 1);
    cycles(2);
    #1 rst_n = 1'b1;
    @(negedge clk);
    mark();
    cycles(100);
    delta(0, 0, 0);
    mark();
    push(3, 9'h01F);
    cycles(40);
    delta(3, 32, 1);
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 4; d++) begin
        valid[d] = $urandom_range(0, 5) == 0;
        data[d] = 9'($urandom);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 4; d++) valid[d] = 1'b0;
    cycles(400);
    for (int d = 0; d < 4; d++) check($sformatf("d%0d_drained", d), cnt_w[d] + act_w[d], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
